// File: rtl/calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | calc_pkg                                                                 |
// | Shared types, constants and helper functions for the calculator datapath.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package calc_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int BCD_W = 4;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >>> 1;
        end
        return result;
    endfunction

    // True when DIGITS decimal digits can hold the largest in_size-bit value.
    function automatic bit digits_ok(input int in_size, input int digits);
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10 = 1;
        for (int i = 0; i < digits; i++) begin
            pow10 = pow10 * 10;
        end
        max_bin = (longint'(1) << in_size) - 1;
        return pow10 > max_bin;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_add3                                                                 |
// | Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule
`default_nettype wire

// File: rtl/bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bcd_converter                                                            |
// | Iterative shift-and-add-3 binary to packed BCD converter, 1 bit/clock.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bcd_converter
    import calc_pkg::*;
#(
    parameter int inSize = 5,
    parameter int DIGITS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [inSize-1:0]         bin,
    input  logic                      in_valid,
    output logic [BCD_W*DIGITS-1:0]   bcd,
    output logic                      valid,
    output logic                      busy
);

    localparam int ACC_W = BCD_W * DIGITS;
    localparam int CNT_W = clog2(inSize + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(inSize - 1);

    if (!digits_ok(inSize, DIGITS)) begin : g_digits_check
        $error("bcd_converter: DIGITS=%0d too small for inSize=%0d", DIGITS, inSize);
    end

    state_t                    state;
    state_t                    state_next;
    logic [inSize-1:0]         sr;
    logic [ACC_W-1:0]          acc;
    logic [ACC_W-1:0]          acc_fix;
    logic [CNT_W-1:0]          cnt;
    logic [ACC_W+inSize-1:0]   shifted;
    logic                      last_shift;

    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[d*BCD_W +: BCD_W]),
            .dout (acc_fix[d*BCD_W +: BCD_W])
        );
    end

    // Corrected accumulator and operand shift together; sr MSB enters acc LSB.
    assign shifted    = {acc_fix, sr} << 1;
    assign last_shift = (state == SHIFT) && (cnt == LAST_CNT);
    assign busy       = (state == SHIFT);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)         state_next = SHIFT;
            SHIFT:   if (cnt == LAST_CNT)  state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            sr    <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd   <= '0;
            valid <= 1'b0;
        end else if (en) begin
            state <= state_next;
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sr  <= bin;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= shifted[ACC_W+inSize-1:inSize];
                    sr  <= shifted[inSize-1:0];
                    cnt <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        bcd   <= shifted[ACC_W+inSize-1:inSize];
                        valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_converter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bcd_converter                                                         |
// | Directed self-checking bench for bcd_converter (5/2 and 8/3 variants).   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bcd_converter;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  bin;
    logic        in_valid;
    logic [7:0]  bcd;
    logic        valid;
    logic        busy;

    logic [7:0]  bin8;
    logic        in_valid8;
    logic [11:0] bcd8;
    logic        valid8;
    logic        busy8;

    int tests = 0;
    int fails = 0;

    bcd_converter #(.inSize(5), .DIGITS(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bin      (bin),
        .in_valid (in_valid),
        .bcd      (bcd),
        .valid    (valid),
        .busy     (busy)
    );

    bcd_converter #(.inSize(8), .DIGITS(3)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bin      (bin8),
        .in_valid (in_valid8),
        .bcd      (bcd8),
        .valid    (valid8),
        .busy     (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand and wait (bounded) for its valid pulse.
    task automatic convert(input logic [4:0] v, output logic [7:0] got,
                           output int lat, output int busy_cycles);
        bin      = v;
        in_valid = 1'b1;
        tick();
        in_valid    = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (!valid && lat < 40) begin
            if (busy) busy_cycles++;
            tick();
            lat++;
        end
        got = bcd;
        if (!valid) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        bin = '0; bin8 = '0;
        tick(); tick();
        tests++; if (bcd !== 8'h00)  begin fails++; $display("FAIL reset_bcd: got %h expected 00", bcd); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", valid); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (bcd8 !== 12'h000) begin fails++; $display("FAIL reset_bcd8: got %h expected 000", bcd8); end
        rst = 1'b1; en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] got;
        int lat, bc;
        convert(5'd3, got, lat, bc);
        tests++; if (lat !== 5)     begin fails++; $display("FAIL single_latency: got %0d expected 5", lat); end
        tests++; if (bc !== 5)      begin fails++; $display("FAIL single_busy_cycles: got %0d expected 5", bc); end
        tests++; if (got !== 8'h03) begin fails++; $display("FAIL single_bcd: got %h expected 03", got); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_in_valid: got %b expected 0", busy); end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b expected 0", valid); end
    endtask

    task automatic test_sequence();
        logic [4:0] vin [3] = '{5'd31, 5'd19, 5'd0};
        logic [7:0] vexp [3] = '{8'h31, 8'h19, 8'h00};
        logic [7:0] got;
        int lat, bc, extra;
        for (int i = 0; i < 3; i++) begin
            convert(vin[i], got, lat, bc);
            tests++; if (got !== vexp[i]) begin fails++; $display("FAIL seq_bcd[%0d]: got %h expected %h", i, got, vexp[i]); end
            tests++; if (lat !== 5) begin fails++; $display("FAIL seq_latency[%0d]: got %0d expected 5", i, lat); end
            extra = 0;
            repeat (3) begin tick(); if (valid) extra++; end
            tests++; if (extra !== 0) begin fails++; $display("FAIL seq_single_pulse[%0d]: got %0d extra expected 0", i, extra); end
        end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        bin      = 5'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_v = (i % 6 == 5);
            tests++; if (valid !== exp_v) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected %b", i, valid, exp_v); end
            tests++; if (busy !== !exp_v) begin fails++; $display("FAIL b2b_busy[%0d]: got %b expected %b", i, busy, !exp_v); end
            if (exp_v) begin
                tests++; if (bcd !== 8'h10) begin fails++; $display("FAIL b2b_bcd[%0d]: got %h expected 10", i, bcd); end
            end
        end
        in_valid = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_enable();
        int lat;
        bin      = 5'd27;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        tick(); lat++;
        tick(); lat++;
        en = 1'b0;
        repeat (3) begin tick(); lat++; end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL en_busy_frozen: got %b expected 1", busy); end
        en = 1'b1;
        while (!valid && lat < 40) begin tick(); lat++; end
        tests++; if (lat !== 8)     begin fails++; $display("FAIL en_latency: got %0d expected 8", lat); end
        tests++; if (bcd !== 8'h27) begin fails++; $display("FAIL en_bcd: got %h expected 27", bcd); end
        en = 1'b0;
        tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL en_valid_stretch1: got %b expected 1", valid); end
        tick();
        tests++; if (valid !== 1'b1) begin fails++; $display("FAIL en_valid_stretch2: got %b expected 1", valid); end
        en = 1'b1;
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL en_valid_release: got %b expected 0", valid); end
    endtask

    task automatic test_reset_abort();
        logic [7:0] got;
        int lat, bc, seen;
        bin      = 5'd25;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        tests++; if (bcd !== 8'h00)  begin fails++; $display("FAIL abort_bcd: got %h expected 00", bcd); end
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b expected 0", valid); end
        tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
        rst  = 1'b1;
        seen = 0;
        repeat (8) begin tick(); if (valid || busy) seen++; end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d active cycles expected 0", seen); end
        convert(5'd7, got, lat, bc);
        tests++; if (got !== 8'h07) begin fails++; $display("FAIL abort_next_bcd: got %h expected 07", got); end
        tests++; if (lat !== 5)     begin fails++; $display("FAIL abort_next_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_wide();
        int lat;
        bin8      = 8'd255;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!valid8 && lat < 40) begin tick(); lat++; end
        tests++; if (lat !== 8)        begin fails++; $display("FAIL wide_latency: got %0d expected 8", lat); end
        tests++; if (bcd8 !== 12'h255) begin fails++; $display("FAIL wide_bcd: got %h expected 255", bcd8); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_back_to_back();
        test_enable();
        test_reset_abort();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_converter.md
# bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the calculator's adder. It accepts the adder's unsigned binary `sum` when the adder's `valid` is asserted, then converts it iteratively with shift-and-add-3 (double dabble), one bit per clock. It presents packed BCD digits with a one-cycle `valid` pulse to the display/output stage.

## Interface
- `inSize`, default 5: width of the binary input; matches the adder's `sum` width for a 4-bit adder.
- `DIGITS`, default 2: number of BCD output digits. Must satisfy 10^DIGITS > 2^inSize − 1; otherwise elaboration stops with `$error`.
- `clk`  in  1  system clock; all logic on the rising edge. This is the design's one clock.
- `rst`  in  1  reset, synchronous and active-low; sampled on the `clk` rising edge.
- `en`  in  1  clock enable; when low, every register holds.
- `bin`  in  `inSize`  unsigned binary operand, driven by the adder's `sum`.
- `in_valid`  in  1  `bin` is valid, driven by the adder's `valid`; level-sensitive.
- `bcd`  out  4*DIGITS  packed BCD result; digit 0 is in `bcd[3:0]`.
- `valid`  out  1  one-cycle pulse: `bcd` has just been updated.
- `busy`  out  1  high while a conversion is in progress; `in_valid` is ignored while high.

## Operation
- Two states: IDLE and SHIFT. Internal registers:
  - shift register `sr` of width `inSize`
  - scratch BCD accumulator `acc` of width 4*DIGITS
  - bit counter `cnt` of width clog2(inSize+1)
- IDLE: on an edge with `en`=1 and `in_valid`=1:
  - load `sr`←`bin`, `acc`←0, `cnt`←0
  - go to SHIFT
- SHIFT: on each edge with `en`=1:
  - Correct every 4-bit digit of `acc` that is ≥5 by adding 3.
  - Shift {corrected `acc`, `sr`} left by 1, so the MSB of `sr` enters the LSB of `acc`.
  - Increment `cnt`.
- On the edge where `cnt` = `inSize`−1 (the final shift):
  - `bcd` ← final shifted value
  - `valid` ← 1
  - state ← IDLE
- `valid` is cleared on the next `en`=1 edge.
- `busy` = (state == SHIFT). It is combinational from the state register.
- `bcd` holds its last result until the next conversion completes.
- `in_valid` held high continuously produces back-to-back conversions. The upstream adder keeps `valid` asserted, and repeated identical results are acceptable.
- Arithmetic: unsigned only.
  - Each add-3 correction stays within its 4-bit digit.
  - With a legal `DIGITS`, no carry leaves the top digit.
  - The `bin` value 0 converts to all-zero digits.

## Timing
- Reset values (the edge where `rst`=0, regardless of `en`):
  - state=IDLE, `sr`=0, `acc`=0, `cnt`=0
  - `bcd`=0, `valid`=0, `busy`=0
- Latency: `in_valid` accepted at edge E → `valid` high and `bcd` updated after edge E+`inSize`.
- Throughput: the earliest next acceptance is at edge E+`inSize`+1, the cycle in which `valid` is high. So one conversion completes every `inSize`+1 cycles.
- `en` low:
  - Freezes state, counter, `sr`, `acc`, `bcd` and `valid`.
  - A `valid` pulse in progress is stretched until the next `en`=1 edge.
  - `in_valid` is not sampled.
- Reset mid-conversion: aborts immediately to the reset values. No `valid` is produced for the aborted operand.
- `in_valid` during SHIFT: ignored, not queued.
- Simultaneous final shift and `in_valid`=1: the final-shift edge only completes the current conversion. The new operand is accepted on the following edge, from IDLE.

## Structure
- Shared package `calc_pkg`:
  - state enum {IDLE, SHIFT}
  - constant BCD_W = 4
  - function `clog2`
  - the DIGITS legality check as a reusable function
- One sub-module `bcd_add3`: combinational 4-bit "if ≥5 add 3" correction. It is instantiated DIGITS times in a generate loop.
- No memories. Everything else is in one always block for the registers plus continuous assigns.

## Test plan
All scenarios use `inSize`=5 and `DIGITS`=2 unless noted.
1. Release reset, then pulse `in_valid` with `bin`=3 (1+2 from the adder) → `busy` high for 5 cycles; `valid` high for exactly one cycle 5 edges after acceptance; `bcd`=8'h03.
2. Convert `bin`=31, `bin`=19 and `bin`=0 sequentially → `bcd` = 8'h31, 8'h19, 8'h00 respectively; each `valid` fires exactly once.
3. Hold `in_valid`=1 with `bin`=10 for 20 cycles → `valid` pulses every 6 cycles, each with `bcd`=8'h10; `busy` is low only in the `valid` cycles.
4. Drop `en` for 3 cycles in the middle of converting `bin`=27 → completion is delayed by exactly 3 cycles; `bcd`=8'h27. Also drop `en` in the `valid` cycle → `valid` stays high until `en` returns.
5. Assert `rst`=0 two cycles into converting `bin`=25 → all outputs are 0 on the next edge and no `valid` appears. A new `bin`=7 after release gives `bcd`=8'h07.
6. Parameter check: `inSize`=8, `DIGITS`=3, `bin`=255 → `bcd`=12'h255 after 8 edges. `inSize`=8 with `DIGITS`=2 → elaboration `$error`.
